// File: rtl/issue_hazard_ctrl.sv
// Issue/hazard controller between decode and EX.
// Keeps a shadow of the EX/MEM/WB destination state. From that shadow it
// picks forwarding sources, inserts load-use bubbles, kills decode on a taken
// branch and drives the decode allowin/valid handshake.
module issue_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ds_valid_i,
   input  logic              ds_rj_re_i,
   input  logic [REG_AW-1:0] ds_rj_i,
   input  logic              ds_rk_re_i,
   input  logic [REG_AW-1:0] ds_rk_i,
   input  logic              ds_we_i,
   input  logic [REG_AW-1:0] ds_dest_i,
   input  logic              ds_is_load_i,
   input  logic              br_taken_i,
   input  logic              pipe_hold_i,
   input  logic              cnt_clr_i,
   output logic              ds_allowin_o,
   output logic              ds_to_es_valid_o,
   output logic [1:0]        fwd_rj_sel_o,
   output logic [1:0]        fwd_rk_sel_o,
   output logic              load_use_stall_o,
   output logic              flush_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [REG_AW-1:0] dest;
      logic              isLoad;
   } shadow_t;

   shadow_t es_q, ms_q, ws_q;
   shadow_t es_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

   logic rjEx, rjMs, rjWs;
   logic rkEx, rkMs, rkWs;
   logic loadUse;
   logic readyGo;
   logic flush;
   logic toEs;
   logic stallInc;

   // A source hits a stage only when that stage really writes a non-zero GPR
   // equal to the source, and the source is actually read. r0 never forwards.
   function automatic logic srcMatch(input shadow_t e, input logic re,
                                     input logic [REG_AW-1:0] src);
      return re & e.valid & e.we & (e.dest != '0) & (e.dest == src);
   endfunction

   // Hazard detection, forward selection with EX > MEM > WB priority, and
   // the issue handshake. A flush suppresses issue but not the stall report.
   always_comb begin
      rjEx = srcMatch(es_q, ds_rj_re_i, ds_rj_i);
      rjMs = srcMatch(ms_q, ds_rj_re_i, ds_rj_i);
      rjWs = srcMatch(ws_q, ds_rj_re_i, ds_rj_i);
      rkEx = srcMatch(es_q, ds_rk_re_i, ds_rk_i);
      rkMs = srcMatch(ms_q, ds_rk_re_i, ds_rk_i);
      rkWs = srcMatch(ws_q, ds_rk_re_i, ds_rk_i);

      fwd_rj_sel_o = 2'd0;
      if (rjEx)      fwd_rj_sel_o = 2'd1;
      else if (rjMs) fwd_rj_sel_o = 2'd2;
      else if (rjWs) fwd_rj_sel_o = 2'd3;

      fwd_rk_sel_o = 2'd0;
      if (rkEx)      fwd_rk_sel_o = 2'd1;
      else if (rkMs) fwd_rk_sel_o = 2'd2;
      else if (rkWs) fwd_rk_sel_o = 2'd3;

      loadUse  = ds_valid_i & (rjEx | rkEx) & es_q.isLoad;
      readyGo  = ~loadUse;
      flush    = br_taken_i & es_q.valid & ~pipe_hold_i;
      toEs     = ds_valid_i & readyGo & ~pipe_hold_i & ~flush;
      stallInc = loadUse & ~pipe_hold_i;

      ds_allowin_o     = ~ds_valid_i | (readyGo & ~pipe_hold_i);
      ds_to_es_valid_o = toEs;
      load_use_stall_o = stallInc;
      flush_o          = flush;
   end

   // Next EX shadow entry: the issuing instruction, or an all-zero bubble.
   // Next counter value: clear beats increment, and the count saturates.
   always_comb begin
      es_d = '0;
      if (toEs) begin
         es_d.valid  = 1'b1;
         es_d.we     = ds_we_i;
         es_d.dest   = ds_dest_i;
         es_d.isLoad = ds_is_load_i;
      end

      stallCnt_d = stallCnt_q;
      if (cnt_clr_i)
         stallCnt_d = '0;
      else if (stallInc && (stallCnt_q != {CNT_W{1'b1}}))
         stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Shadow shift register advances only when the back end is not held;
   // the stall counter updates every cycle since its increment is hold-gated.
   always_ff @(posedge clk) begin
      if (rst) begin
         es_q       <= '0;
         ms_q       <= '0;
         ws_q       <= '0;
         stallCnt_q <= '0;
      end else begin
         if (!pipe_hold_i) begin
            ws_q <= ms_q;
            ms_q <= es_q;
            es_q <= es_d;
         end
         stallCnt_q <= stallCnt_d;
      end
   end

   assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed testbench for issue_hazard_ctrl.
// The counter is built narrow here so that saturation is reached in a few
// dozen cycles instead of tens of thousands.
module tb_issue_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              dsValid;
   logic              rjRe;
   logic [REG_AW-1:0] rj;
   logic              rkRe;
   logic [REG_AW-1:0] rk;
   logic              we;
   logic [REG_AW-1:0] dest;
   logic              isLoad;
   logic              brTaken;
   logic              pipeHold;
   logic              cntClr;
   logic              allowin;
   logic              toEs;
   logic [1:0]        rjSel;
   logic [1:0]        rkSel;
   logic              stall;
   logic              flush;
   logic [CNT_W-1:0]  stallCnt;

   int vecCount = 0;
   int errCount = 0;

   issue_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .ds_valid_i       (dsValid),
      .ds_rj_re_i       (rjRe),
      .ds_rj_i          (rj),
      .ds_rk_re_i       (rkRe),
      .ds_rk_i          (rk),
      .ds_we_i          (we),
      .ds_dest_i        (dest),
      .ds_is_load_i     (isLoad),
      .br_taken_i       (brTaken),
      .pipe_hold_i      (pipeHold),
      .cnt_clr_i        (cntClr),
      .ds_allowin_o     (allowin),
      .ds_to_es_valid_o (toEs),
      .fwd_rj_sel_o     (rjSel),
      .fwd_rk_sel_o     (rkSel),
      .load_use_stall_o (stall),
      .flush_o          (flush),
      .stall_cnt_o      (stallCnt)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one decode-stage instruction and let combinational logic settle.
   task automatic applyStimulus(input logic v, input logic jRe, input logic [4:0] j,
                                input logic kRe, input logic [4:0] k, input logic w,
                                input logic [4:0] d, input logic ld);
      dsValid = v;
      rjRe    = jRe;
      rj      = j;
      rkRe    = kRe;
      rk      = k;
      we      = w;
      dest    = d;
      isLoad  = ld;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      assert (obs === exp)
      else begin
         errCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, then step just past it before the next drive.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      rst = 1'b1; brTaken = 1'b0; pipeHold = 1'b0; cntClr = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("rst_allowin", allowin, 1);
      checkOutput("rst_toes", toEs, 0);
      checkOutput("rst_rjsel", rjSel, 0);
      checkOutput("rst_rksel", rkSel, 0);
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_flush", flush, 0);
      checkOutput("rst_cnt", stallCnt, 0);
      rst = 1'b0;

      // add.w r5,r1,r2 then add.w r6,r5,r3
      applyStimulus(1, 1, 1, 1, 2, 1, 5, 0);
      checkOutput("b2b_first_toes", toEs, 1);
      checkOutput("b2b_first_rjsel", rjSel, 0);
      tick();
      applyStimulus(1, 1, 5, 1, 3, 1, 6, 0);
      checkOutput("b2b_rjsel", rjSel, 1);
      checkOutput("b2b_rksel", rkSel, 0);
      checkOutput("b2b_stall", stall, 0);
      checkOutput("b2b_toes", toEs, 1);
      tick();

      // ld.w r7 then add.w r8,r7,r7
      applyStimulus(1, 1, 1, 0, 0, 1, 7, 1);
      checkOutput("ld_issue_rjsel", rjSel, 0);
      checkOutput("ld_issue_toes", toEs, 1);
      tick();
      applyStimulus(1, 1, 7, 1, 7, 1, 8, 0);
      checkOutput("lu_stall", stall, 1);
      checkOutput("lu_allowin", allowin, 0);
      checkOutput("lu_toes", toEs, 0);
      tick();
      checkOutput("lu_after_stall", stall, 0);
      checkOutput("lu_after_rjsel", rjSel, 2);
      checkOutput("lu_after_rksel", rkSel, 2);
      checkOutput("lu_after_toes", toEs, 1);
      checkOutput("lu_cnt", stallCnt, 1);
      tick();

      // ld.w r0 then use r0: no hazard on r0
      applyStimulus(1, 1, 1, 0, 0, 1, 0, 1);
      tick();
      applyStimulus(1, 1, 0, 1, 0, 1, 9, 0);
      checkOutput("r0_stall", stall, 0);
      checkOutput("r0_rjsel", rjSel, 0);
      checkOutput("r0_rksel", rkSel, 0);
      checkOutput("r0_toes", toEs, 1);
      tick();

      // EX=r9, MEM=ld r0, WB=r8: producer three ahead
      applyStimulus(1, 1, 8, 0, 0, 1, 10, 0);
      checkOutput("dist3_rjsel", rjSel, 3);
      tick();
      // EX=r10, MEM=r9, WB=ld r0: r8 four ahead, r9 in MEM
      applyStimulus(1, 1, 8, 1, 9, 1, 11, 0);
      checkOutput("dist4_rjsel", rjSel, 0);
      checkOutput("mem_rksel", rkSel, 2);
      tick();
      // EX=r11, MEM=r10, WB=r9
      applyStimulus(1, 1, 11, 1, 9, 1, 11, 0);
      checkOutput("ex_rjsel", rjSel, 1);
      checkOutput("wb_rksel", rkSel, 3);
      tick();
      // EX=r11, MEM=r11: EX wins; unread source never forwards
      applyStimulus(0, 1, 11, 0, 11, 0, 0, 0);
      checkOutput("prio_rjsel", rjSel, 1);
      checkOutput("nore_rksel", rkSel, 0);
      checkOutput("idle_allowin", allowin, 1);
      checkOutput("idle_toes", toEs, 0);
      tick();

      // beq issues, then is taken while decode holds add.w r12
      applyStimulus(1, 1, 1, 1, 2, 0, 0, 0);
      checkOutput("beq_toes", toEs, 1);
      tick();
      applyStimulus(1, 1, 1, 1, 2, 1, 12, 0);
      brTaken = 1'b1;
      #1;
      checkOutput("br_flush", flush, 1);
      checkOutput("br_toes", toEs, 0);
      checkOutput("br_allowin", allowin, 1);
      tick();
      checkOutput("br_bubble_flush", flush, 0);
      checkOutput("br_bubble_toes", toEs, 1);
      tick();

      // Taken branch (add r12 in EX, valid) under hold: no flush until release
      applyStimulus(1, 1, 1, 1, 2, 1, 13, 0);
      pipeHold = 1'b1;
      #1;
      checkOutput("brhold_flush", flush, 0);
      checkOutput("brhold_toes", toEs, 0);
      checkOutput("brhold_allowin", allowin, 0);
      tick();
      checkOutput("brhold2_flush", flush, 0);
      pipeHold = 1'b0;
      #1;
      checkOutput("brrel_flush", flush, 1);
      checkOutput("brrel_toes", toEs, 0);
      tick();
      brTaken = 1'b0;

      // Load in EX and dependent in decode, held for three cycles
      applyStimulus(1, 1, 1, 0, 0, 1, 14, 1);
      tick();
      applyStimulus(1, 1, 14, 0, 0, 1, 15, 0);
      pipeHold = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("hold_stall", stall, 0);
         checkOutput("hold_allowin", allowin, 0);
         checkOutput("hold_cnt", stallCnt, 1);
         tick();
      end
      pipeHold = 1'b0;
      #1;
      checkOutput("rel_stall", stall, 1);
      checkOutput("rel_rjsel", rjSel, 1);
      checkOutput("rel_cnt", stallCnt, 1);
      tick();
      checkOutput("rel2_stall", stall, 0);
      checkOutput("rel2_rjsel", rjSel, 2);
      checkOutput("rel2_toes", toEs, 1);
      checkOutput("rel2_cnt", stallCnt, 2);
      tick();

      // Flush and load-use together: flush wins, stall still counted
      applyStimulus(1, 1, 1, 0, 0, 1, 16, 1);
      tick();
      applyStimulus(1, 0, 0, 1, 16, 1, 17, 0);
      brTaken = 1'b1;
      #1;
      checkOutput("fl_lu_flush", flush, 1);
      checkOutput("fl_lu_stall", stall, 1);
      checkOutput("fl_lu_toes", toEs, 0);
      tick();
      brTaken = 1'b0;
      checkOutput("fl_lu_cnt", stallCnt, 3);

      // Fourteen more load-use pairs: counter saturates at 15
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1, 1, 1, 0, 0, 1, 17, 1);
         tick();
         applyStimulus(1, 1, 17, 0, 0, 1, 18, 0);
         tick();
      end
      checkOutput("sat_cnt", stallCnt, 15);

      // Clear takes priority over a simultaneous stall
      applyStimulus(1, 1, 1, 0, 0, 1, 17, 1);
      tick();
      applyStimulus(1, 1, 17, 0, 0, 1, 18, 0);
      cntClr = 1'b1;
      #1;
      checkOutput("clr_stall", stall, 1);
      tick();
      cntClr = 1'b0;
      checkOutput("clr_cnt", stallCnt, 0);

      // Reset during a stall, with a taken branch pending afterwards
      applyStimulus(1, 1, 1, 0, 0, 1, 18, 1);
      tick();
      applyStimulus(1, 1, 18, 1, 18, 1, 19, 0);
      checkOutput("prerst_stall", stall, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      brTaken = 1'b1;
      #1;
      checkOutput("postrst_stall", stall, 0);
      checkOutput("postrst_flush", flush, 0);
      checkOutput("postrst_rjsel", rjSel, 0);
      checkOutput("postrst_rksel", rkSel, 0);
      checkOutput("postrst_allowin", allowin, 1);
      checkOutput("postrst_toes", toEs, 1);
      checkOutput("postrst_cnt", stallCnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
